// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states and the MDU result FIFO entry.
package wb_arb_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } wb_arb_state_t;

    typedef struct packed {
        logic               v;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } mdu_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the WriteBack, MDU, register-file and hazard-query signals around the write-port arbiter.
interface wb_port_arbiter_if #(parameter int XLEN = 32);

    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            mdu_valid_i;
    logic [4:0]      mdu_rd_i;
    logic [XLEN-1:0] mdu_data_i;
    logic            mdu_ready_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            stall_wb_o;
    logic [4:0]      q_rs1_i;
    logic [4:0]      q_rs2_i;
    logic            pend_rs1_o;
    logic            pend_rs2_o;

    // Arbiter side
    modport slave (
        input  RegWriteW, RdW, ResultW, mdu_valid_i, mdu_rd_i, mdu_data_i, q_rs1_i, q_rs2_i,
        output mdu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_wb_o, pend_rs1_o, pend_rs2_o
    );

    // Pipeline / MDU / register-file side
    modport master (
        output RegWriteW, RdW, ResultW, mdu_valid_i, mdu_rd_i, mdu_data_i, q_rs1_i, q_rs2_i,
        input  mdu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_wb_o, pend_rs1_o, pend_rs2_o
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// Circular buffer of MDU results with per-entry invalidation by destination register.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when count == DEPTH; pop of an empty buffer is not allowed.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [4:0]               i_push_rd,
    input  logic [WB_XLEN-1:0]       i_push_data,
    input  logic                     i_pop,
    input  logic                     i_kill,
    input  logic [4:0]               i_kill_rd,
    input  logic [4:0]               i_q_rs1,
    input  logic [4:0]               i_q_rs2,
    output mdu_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_pend_rs1,
    output logic                     o_pend_rs2
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    mdu_entry_t  r_mem [DEPTH];
    logic [AW:0] r_head;
    logic [AW:0] r_tail;

    // Extra wrap bit makes tail - head the occupancy, including the full case.
    assign o_count = r_tail - r_head;
    assign o_head  = r_mem[r_head[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_mem[i].rd == i_kill_rd)) begin
                    r_mem[i].v <= 1'b0;
                end
            end
            if (i_pop) begin
                r_mem[r_head[AW-1:0]].v <= 1'b0;
                r_head <= r_head + PTR_ONE;
            end
            if (i_push) begin
                r_mem[r_tail[AW-1:0]] <= '{v: 1'b1, rd: i_push_rd, data: i_push_data};
                r_tail <= r_tail + PTR_ONE;
            end
        end
    end

    // Valid bits are cleared on pop, so a set bit always marks an occupied, live slot.
    always_comb begin
        o_pend_rs1 = 1'b0;
        o_pend_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].v && (i_q_rs1 != 5'd0) && (r_mem[i].rd == i_q_rs1)) begin
                o_pend_rs1 = 1'b1;
            end
            if (r_mem[i].v && (i_q_rs2 != 5'd0) && (r_mem[i].rd == i_q_rs2)) begin
                o_pend_rs2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between WriteBack (priority) and queued MDU results.
// Latency: WB writes are combinational; an MDU result writes no earlier than the cycle after acceptance.
// Backpressure: mdu_ready_o drops while the FIFO is full; stall_wb_o freezes the pipeline for a forced drain.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
)(
    input  logic                clk,
    input  logic                rst_n,
    wb_port_arbiter_if.slave    bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT) + 1;

    wb_arb_state_t   r_state;
    wb_arb_state_t   w_state_n;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_n;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_n;
    mdu_entry_t      w_head;
    logic            w_wb_act;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_force;

    assign w_wb_act        = bus.RegWriteW && (bus.RdW != 5'd0);
    assign w_empty         = (w_count == '0);
    assign bus.mdu_ready_o = (w_count != CW'(DEPTH));
    assign w_accept        = bus.mdu_valid_i && bus.mdu_ready_o;
    // rd=0 results and results the same-cycle WB write supersedes complete the handshake but are dropped.
    assign w_push          = w_accept && (bus.mdu_rd_i != 5'd0)
                             && !(w_wb_act && (bus.mdu_rd_i == bus.RdW));

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_rd   (bus.mdu_rd_i),
        .i_push_data (bus.mdu_data_i),
        .i_pop       (w_pop),
        .i_kill      (w_wb_act),
        .i_kill_rd   (bus.RdW),
        .i_q_rs1     (bus.q_rs1_i),
        .i_q_rs2     (bus.q_rs2_i),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_pend_rs1  (bus.pend_rs1_o),
        .o_pend_rs2  (bus.pend_rs2_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_n;
            r_wait  <= w_wait_n;
        end
    end

    always_comb begin
        w_count_n = w_count + CW'(w_push) - CW'(w_pop);
        w_wait_n  = r_wait;
        if (w_empty || w_pop || (w_count_n == '0)) begin
            w_wait_n = '0;
        end else if (r_wait != WW'(MAX_WAIT - 1)) begin
            w_wait_n = r_wait + WW'(1);
        end
        w_force = (w_count_n == CW'(DEPTH))
                  || (!w_pop && (w_count_n != '0) && (w_wait_n == WW'(MAX_WAIT - 1)));
        if (w_force) begin
            w_state_n = S_FORCE;
        end else if (w_count_n != '0) begin
            w_state_n = S_PEND;
        end else begin
            w_state_n = S_IDLE;
        end
    end

    // A killed head pops silently on any cycle; the WB write in S_FORCE is held back by the stall.
    always_comb begin
        bus.stall_wb_o = (r_state == S_FORCE);
        w_pop          = !w_empty && ((r_state == S_FORCE) || !w_wb_act || !w_head.v);
        bus.rf_we_o    = 1'b0;
        bus.rf_waddr_o = 5'd0;
        bus.rf_wdata_o = '0;
        if (w_pop && w_head.v) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_waddr_o = w_head.rd;
            bus.rf_wdata_o = w_head.data;
        end else if (w_wb_act && (r_state != S_FORCE)) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_waddr_o = bus.RdW;
            bus.rf_wdata_o = bus.ResultW;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(32)) bus();

    wb_port_arbiter #(.XLEN(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: program-order queue of pending MDU results.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          v;
    } ment_t;

    ment_t mq[$];
    bit    m_init  = 1'b0;
    bit    m_force = 1'b0;
    int    m_wait  = 0;

    always @(negedge clk) begin : model
        bit          wb, full, hv, deq, acc, e_we, e_p1, e_p2;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          sz0;
        if (m_init) begin
            wb   = bus.RegWriteW && (bus.RdW != 5'd0);
            sz0  = mq.size();
            full = (sz0 == DEPTH);
            hv   = (sz0 > 0) && mq[0].v;
            deq  = (sz0 > 0) && (m_force || !wb || !hv);
            e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
            if (deq && hv) begin
                e_we = 1'b1; e_addr = mq[0].rd; e_data = mq[0].data;
            end else if (wb && !m_force) begin
                e_we = 1'b1; e_addr = bus.RdW; e_data = bus.ResultW;
            end
            e_p1 = 1'b0; e_p2 = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].v && bus.q_rs1_i != 5'd0 && mq[i].rd == bus.q_rs1_i) e_p1 = 1'b1;
                if (mq[i].v && bus.q_rs2_i != 5'd0 && mq[i].rd == bus.q_rs2_i) e_p2 = 1'b1;
            end
            chk("m_ready", bus.mdu_ready_o, !full);
            chk("m_stall", bus.stall_wb_o, m_force);
            chk("m_rf_we", bus.rf_we_o, e_we);
            chk("m_rf_waddr", bus.rf_waddr_o, e_addr);
            chk("m_rf_wdata", bus.rf_wdata_o, e_data);
            chk("m_pend1", bus.pend_rs1_o, e_p1);
            chk("m_pend2", bus.pend_rs2_o, e_p2);
            if (rst_n) begin
                acc = bus.mdu_valid_i && !full;
                if (wb) begin
                    foreach (mq[i]) if (mq[i].rd == bus.RdW) mq[i].v = 1'b0;
                end
                if (deq) void'(mq.pop_front());
                if (acc && bus.mdu_rd_i != 5'd0 && !(wb && bus.mdu_rd_i == bus.RdW))
                    mq.push_back('{rd: bus.mdu_rd_i, data: bus.mdu_data_i, v: 1'b1});
                if (sz0 == 0 || deq || mq.size() == 0) m_wait = 0;
                else if (m_wait < MAX_WAIT - 1) m_wait++;
                m_force = (mq.size() == DEPTH) || (!deq && mq.size() > 0 && m_wait == MAX_WAIT - 1);
            end
        end
        if (!rst_n) begin
            mq.delete();
            m_wait  = 0;
            m_force = 1'b0;
            m_init  = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input bit en, input logic [4:0] rd, input logic [31:0] d);
        bus.RegWriteW = en; bus.RdW = rd; bus.ResultW = d;
    endtask

    task automatic mdu(input bit v, input logic [4:0] rd, input logic [31:0] d);
        bus.mdu_valid_i = v; bus.mdu_rd_i = rd; bus.mdu_data_i = d;
    endtask

    initial begin
        wb(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        bus.q_rs1_i = 5'd0;
        bus.q_rs2_i = 5'd0;
        rst_n = 1'b0;

        // 1: reset, idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t1_ready", bus.mdu_ready_o, 1);
        chk("t1_stall", bus.stall_wb_o, 0);
        chk("t1_pend1", bus.pend_rs1_o, 0);
        chk("t1_pend2", bus.pend_rs2_o, 0);
        chk("t1_we", bus.rf_we_o, 0);
        chk("t1_waddr", bus.rf_waddr_o, 0);
        chk("t1_wdata", bus.rf_wdata_o, 0);

        // 2: MDU result drains on idle WB cycle
        step; mdu(1'b1, 5'd5, 32'h1234);
        #1 chk("t2_ready", bus.mdu_ready_o, 1);
        chk("t2_we_same", bus.rf_we_o, 0);
        step; mdu(1'b0, 5'd0, 32'd0);
        #1 chk("t2_we", bus.rf_we_o, 1);
        chk("t2_waddr", bus.rf_waddr_o, 5);
        chk("t2_wdata", bus.rf_wdata_o, 32'h1234);
        step;
        #1 chk("t2_empty_we", bus.rf_we_o, 0);

        // 3: continuous WB starves MDU head -> forced drain in cycle 8
        step; wb(1'b1, 5'd3, 32'hAAAA0003); mdu(1'b1, 5'd7, 32'h77); bus.q_rs1_i = 5'd7;
        step; mdu(1'b0, 5'd0, 32'd0);
        for (int c = 1; c <= 7; c++) begin
            #1 chk("t3_nostall", bus.stall_wb_o, 0);
            chk("t3_pend7", bus.pend_rs1_o, 1);
            chk("t3_wb_addr", bus.rf_waddr_o, 3);
            step;
        end
        #1 chk("t3_stall", bus.stall_wb_o, 1);
        chk("t3_force_addr", bus.rf_waddr_o, 7);
        chk("t3_force_data", bus.rf_wdata_o, 32'h77);
        step;
        #1 chk("t3_after_stall", bus.stall_wb_o, 0);
        chk("t3_after_addr", bus.rf_waddr_o, 3);
        chk("t3_after_pend", bus.pend_rs1_o, 0);
        step; wb(1'b0, 5'd0, 32'd0); bus.q_rs1_i = 5'd0;
        #1 chk("t3_idle_we", bus.rf_we_o, 0);

        // 4: FIFO fills under WB traffic -> forced drain of x8, x9 later
        step; wb(1'b1, 5'd3, 32'hAAAA0003); mdu(1'b1, 5'd8, 32'h88); bus.q_rs2_i = 5'd9;
        #1 chk("t4_rdy0", bus.mdu_ready_o, 1);
        step; mdu(1'b1, 5'd9, 32'h99);
        #1 chk("t4_rdy1", bus.mdu_ready_o, 1);
        step; mdu(1'b0, 5'd0, 32'd0);
        #1 chk("t4_full_rdy", bus.mdu_ready_o, 0);
        chk("t4_stall", bus.stall_wb_o, 1);
        chk("t4_force_addr", bus.rf_waddr_o, 8);
        chk("t4_force_data", bus.rf_wdata_o, 32'h88);
        step;
        #1 chk("t4_rdy_back", bus.mdu_ready_o, 1);
        chk("t4_nostall", bus.stall_wb_o, 0);
        chk("t4_wb_addr", bus.rf_waddr_o, 3);
        chk("t4_pend9", bus.pend_rs2_o, 1);
        for (int c = 4; c <= 9; c++) begin
            step;
            #1 chk("t4_wait_nostall", bus.stall_wb_o, 0);
        end
        step;
        #1 chk("t4_stall9", bus.stall_wb_o, 1);
        chk("t4_addr9", bus.rf_waddr_o, 9);
        chk("t4_data9", bus.rf_wdata_o, 32'h99);
        step; wb(1'b0, 5'd0, 32'd0); bus.q_rs2_i = 5'd0;
        #1 chk("t4_idle_we", bus.rf_we_o, 0);
        chk("t4_idle_stall", bus.stall_wb_o, 0);

        // 5: queued x10 killed by newer WB write of x10
        step; wb(1'b1, 5'd3, 32'hAAAA0003); mdu(1'b1, 5'd10, 32'h1010); bus.q_rs1_i = 5'd10;
        step; mdu(1'b0, 5'd0, 32'd0);
        #1 chk("t5_pend_before", bus.pend_rs1_o, 1);
        step; wb(1'b1, 5'd10, 32'hBEEF);
        #1 chk("t5_wb_addr", bus.rf_waddr_o, 10);
        chk("t5_wb_data", bus.rf_wdata_o, 32'hBEEF);
        step; wb(1'b0, 5'd0, 32'd0);
        #1 chk("t5_pend_killed", bus.pend_rs1_o, 0);
        chk("t5_no_write", bus.rf_we_o, 0);
        step; bus.q_rs1_i = 5'd0;
        #1 chk("t5_drained_we", bus.rf_we_o, 0);
        chk("t5_ready", bus.mdu_ready_o, 1);

        // 6a: rd=0 result accepted, never written
        step; mdu(1'b1, 5'd0, 32'h5);
        #1 chk("t6_rd0_ready", bus.mdu_ready_o, 1);
        step; mdu(1'b0, 5'd0, 32'd0);
        #1 chk("t6_rd0_we", bus.rf_we_o, 0);

        // 6b: same-cycle MDU result for the WB destination is dropped
        step; wb(1'b1, 5'd13, 32'hD); mdu(1'b1, 5'd13, 32'hE);
        #1 chk("t6_same_addr", bus.rf_waddr_o, 13);
        chk("t6_same_data", bus.rf_wdata_o, 32'hD);
        step; wb(1'b0, 5'd0, 32'd0); mdu(1'b0, 5'd0, 32'd0);
        #1 chk("t6_same_dropped", bus.rf_we_o, 0);

        // 6c: reset with two entries queued discards them
        step; wb(1'b1, 5'd3, 32'hAAAA0003); mdu(1'b1, 5'd11, 32'hB); bus.q_rs1_i = 5'd11;
        step; mdu(1'b1, 5'd12, 32'hC);
        step; mdu(1'b0, 5'd0, 32'd0); rst_n = 1'b0;
        #1 chk("t6_rst_cycle_stall", bus.stall_wb_o, 1);
        step; rst_n = 1'b1; wb(1'b0, 5'd0, 32'd0);
        #1 chk("t6_post_rst_we", bus.rf_we_o, 0);
        chk("t6_post_rst_ready", bus.mdu_ready_o, 1);
        chk("t6_post_rst_stall", bus.stall_wb_o, 0);
        chk("t6_post_rst_pend", bus.pend_rs1_o, 0);
        repeat (10) begin
            step;
            #1 chk("t6_no_late_write", bus.rf_we_o, 0);
        end

        step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
